// File: rtl/mod_plpprobe.sv
// mod_plpprobe: PLP bus initiator that probes a plpid responder after reset.
// It reads the ID word at BASE and the frequency word at BASE+4. It checks the
// ID against EXPECT_ID, latches the frequency, and then derives a
// fractional-rate tick of TICK_HZ Hz from that frequency.
//
// Optional feature, controlled by the macro PLPPROBE_TICK_EN:
//   defined   - the phase accumulator and the tick output are built.
//   undefined - there is no accumulator and tick is tied to 0. S_RUN only holds
//               valid and waits for reprobe.
module mod_plpprobe #(
  parameter logic [31:0] BASE      = 32'h0,
  parameter logic [31:0] EXPECT_ID = 32'hdeadbeef,
  parameter logic [31:0] TICK_HZ   = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        de,
  output logic [31:0] daddr,
  output logic        drw,
  output logic [31:0] dout,
  input  logic [31:0] din,
  input  logic        reprobe,
  output logic [31:0] id,
  output logic [31:0] freq,
  output logic        valid,
  output logic        err,
  output logic        tick
);

  typedef enum logic [1:0] {
    S_RD_ID   = 2'd0,
    S_RD_FREQ = 2'd1,
    S_RUN     = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] id_q, id_d;
  logic [31:0] freq_q, freq_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Next-state logic: the probe sequence, the capture of id/freq and the
  // status flags.
  // NOTE: every signal gets a default before the case statement. Without
  // these defaults, a path that leaves a signal unassigned infers a latch.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    freq_d  = freq_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      S_RD_ID: begin
        id_d = din;
        if (din == EXPECT_ID) begin
          state_d = S_RD_FREQ;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_RD_FREQ: begin
        freq_d = din;
        // A frequency below TICK_HZ (including 0) cannot carry the tick rate.
        if (din < TICK_HZ) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_RUN;
          valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (reprobe) begin
          state_d = S_RD_ID;
          valid_d = 1'b0;
        end
      end
      S_ERR: begin
        if (reprobe) begin
          state_d = S_RD_ID;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_RD_ID;
    endcase
  end

  // State and capture registers with a synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge, whatever order the code runs in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RD_ID;
      id_q    <= 32'h0;
      freq_q  <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

`ifdef PLPPROBE_TICK_EN
  // acc is kept below freq. Adding TICK_HZ (which is <= freq) therefore fits
  // in 33 bits.
  logic [32:0] acc_q, acc_d;
  logic [32:0] acc_sum;
  logic        acc_wrap;
  logic        tick_q, tick_d;

  // Phase accumulator. It runs only in S_RUN. A reprobe clears it and
  // suppresses any wrap in the same cycle.
  always_comb begin
    acc_sum  = acc_q + {1'b0, TICK_HZ};
    acc_wrap = (acc_sum >= {1'b0, freq_q});
    acc_d    = acc_q;
    tick_d   = 1'b0;
    if (state_q == S_RUN) begin
      if (reprobe) begin
        acc_d = 33'h0;
      end else if (acc_wrap) begin
        acc_d  = acc_sum - {1'b0, freq_q};
        tick_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Accumulator and registered tick pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q  <= 33'h0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

  // Bus request decode. It is gated by rst so that the bus stays idle
  // combinationally while reset is held.
  always_comb begin
    de    = 1'b0;
    daddr = 32'h0;
    if (rst) begin
      case (state_q)
        S_RD_ID: begin
          de    = 1'b1;
          daddr = BASE;
        end
        S_RD_FREQ: begin
          de    = 1'b1;
          daddr = BASE + 32'd4;
        end
        default: begin
          de    = 1'b0;
          daddr = 32'h0;
        end
      endcase
    end
  end

  assign drw   = 1'b0;
  assign dout  = 32'h0;
  assign id    = id_q;
  assign freq  = freq_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule
